// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Owns HI/LO and holds the pipeline via MDUReadyE while an operation runs.
module mul_div_unit #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  MDUOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  input  logic        HoldE,
  output logic        MDUReadyE,
  output logic [31:0] HiLoOutE
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] hi, lo;
  logic [31:0] res_hi, res_lo;
  logic [31:0] op_a, op_b;
  logic [4:0]  cnt;
  logic        sgn, neg_q, neg_r;

  logic        is_mul, is_div, is_sgn, start;
  logic [31:0] abs_a, abs_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] shifted, diff;
  logic        fits;
  logic [31:0] rem_nx, q_nx;

  assign is_mul = (MDUOpE == 4'd1) || (MDUOpE == 4'd2);
  assign is_div = (MDUOpE == 4'd3) || (MDUOpE == 4'd4);
  assign is_sgn = (MDUOpE == 4'd1) || (MDUOpE == 4'd3);
  assign start  = (is_mul || is_div) && (state == IDLE) && !FlushE;

  assign abs_a = (is_sgn && SrcAE[31]) ? -SrcAE : SrcAE;
  assign abs_b = (is_sgn && SrcBE[31]) ? -SrcBE : SrcBE;

  assign ext_a = {{32{sgn & op_a[31]}}, op_a};
  assign ext_b = {{32{sgn & op_b[31]}}, op_b};
  assign prod  = ext_a * ext_b;

  // Restoring step: res_hi is the partial remainder, op_a shifts the
  // dividend out at the top and the quotient in at the bottom.
  assign shifted = {res_hi, op_a[31]};
  assign diff    = shifted - {1'b0, op_b};
  assign fits    = !diff[32];
  assign rem_nx  = fits ? diff[31:0] : shifted[31:0];
  assign q_nx    = {op_a[30:0], fits};

  assign MDUReadyE = !((state == IDLE && start) ||
                       state == MUL || state == DIV);

  always_comb begin
    HiLoOutE = 32'd0;
    if (MDUOpE == 4'd5) HiLoOutE = hi;
    else if (MDUOpE == 4'd6) HiLoOutE = lo;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && is_mul) begin
            op_a  <= SrcAE;
            op_b  <= SrcBE;
            sgn   <= is_sgn;
            cnt   <= 5'(MUL_LAT - 1);
            state <= MUL;
          end else if (start && is_div) begin
            op_a   <= abs_a;
            op_b   <= abs_b;
            res_hi <= '0;
            neg_q  <= is_sgn && (SrcAE[31] ^ SrcBE[31]);
            neg_r  <= is_sgn && SrcAE[31];
            cnt    <= 5'd31;
            state  <= DIV;
          end else if (!HoldE && !FlushE) begin
            if (MDUOpE == 4'd7) hi <= SrcAE;
            if (MDUOpE == 4'd8) lo <= SrcAE;
          end
        end
        MUL: begin
          if (FlushE) begin
            state <= IDLE;
          end else if (cnt == 5'd0) begin
            res_hi <= prod[63:32];
            res_lo <= prod[31:0];
            state  <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          if (FlushE) begin
            state <= IDLE;
          end else if (cnt == 5'd0) begin
            res_lo <= neg_q ? -q_nx : q_nx;
            res_hi <= neg_r ? -rem_nx : rem_nx;
            state  <= DONE;
          end else begin
            res_hi <= rem_nx;
            op_a   <= q_nx;
            cnt    <= cnt - 5'd1;
          end
        end
        DONE: begin
          if (FlushE) begin
            state <= IDLE;
          end else if (!HoldE) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
